// File: rtl/irq_timer_bank.sv
// irq_timer_bank: N_CH compare/count timers behind a shared prescaler, raising one
// trap request for the lowest enabled pending channel and tracking it to end-of-interrupt.
//
// state | meaning
// IDLE  | no request outstanding; scanning PEND & IE
// REQ   | irq asserted for irq_id, waiting for irq_ack
// SVC   | handler running, waiting for irq_eoi
module irq_timer_bank #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int PSC_W = 8,
    localparam int AW   = $clog2(N_CH) + 2,
    localparam int IDW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  addr,
    input  logic [31:0]    wdata,
    input  logic           wr_en,
    input  logic           rd_en,
    output logic [31:0]    rdata,
    output logic           irq,
    output logic [IDW-1:0] irq_id,
    input  logic           irq_ack,
    input  logic           irq_eoi
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

    state_t state, state_nx;

    logic [AW-1:0]    ch_sel;
    logic [1:0]       reg_sel;
    logic [N_CH-1:0]  wr_cmp, wr_ctrl, wr_cnt, wr_stat;

    logic [PSC_W-1:0] psc, psc_cnt;
    logic             tick;

    logic [CNT_W-1:0] cmp [N_CH];
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  en, per, ie, pend;
    logic [N_CH-1:0]  tick_ev, match, eoi_clr, req;
    logic [IDW-1:0]   req_id;
    logic             eoi_done;
    logic [31:0]      rd_val;

    assign ch_sel  = addr >> 2;
    assign reg_sel = addr[1:0];

    always_comb begin
        wr_cmp  = '0;
        wr_ctrl = '0;
        wr_cnt  = '0;
        wr_stat = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en && (ch_sel == AW'(i))) begin
                wr_cmp[i]  = (reg_sel == 2'd0);
                wr_ctrl[i] = (reg_sel == 2'd1);
                wr_cnt[i]  = (reg_sel == 2'd2);
                wr_stat[i] = (reg_sel == 2'd3);
            end
        end
    end

    // Up-count with >= so that lowering PSC mid-period never stalls the tick.
    assign tick = (psc_cnt >= psc);

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt <= '0;
            psc     <= '0;
        end else begin
            psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
            if (wr_stat[0]) psc <= wdata[16 +: PSC_W];
        end
    end

    // A software write to CNT or CTRL swallows that channel's tick entirely.
    always_comb begin
        tick_ev = '0;
        match   = '0;
        eoi_clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            tick_ev[i] = tick && en[i] && !wr_cnt[i] && !wr_ctrl[i];
            match[i]   = tick_ev[i] && (cnt[i] == cmp[i]);
            eoi_clr[i] = eoi_done && (irq_id == IDW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cmp[i] <= '0;
                cnt[i] <= '0;
            end
            en   <= '0;
            per  <= '0;
            ie   <= '0;
            pend <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_cmp[i]) cmp[i] <= wdata[CNT_W-1:0];

                if (wr_ctrl[i]) begin
                    en[i]  <= wdata[0];
                    per[i] <= wdata[1];
                    ie[i]  <= wdata[2];
                end else if (match[i] && !per[i]) begin
                    en[i] <= 1'b0;
                end

                if (wr_cnt[i]) begin
                    cnt[i] <= wdata[CNT_W-1:0];
                end else if (match[i]) begin
                    if (per[i]) cnt[i] <= '0;
                end else if (tick_ev[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end

                if (match[i]) begin
                    pend[i] <= 1'b1;
                end else if ((wr_stat[i] && wdata[0]) || eoi_clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == AW'(i)) begin
                case (reg_sel)
                    2'd0: rd_val = 32'(cmp[i]);
                    2'd1: rd_val = {29'd0, ie[i], per[i], en[i]};
                    2'd2: rd_val = 32'(cnt[i]);
                    default: begin
                        rd_val = {31'd0, pend[i]};
                        if (i == 0) rd_val[16 +: PSC_W] = psc;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        rdata <= '0;
        else if (rd_en) rdata <= rd_val;
    end

    assign req = pend & ie;

    always_comb begin
        req_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) req_id = IDW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (|req) state_nx = S_REQ;
            S_REQ: begin
                if (!req[irq_id]) state_nx = S_IDLE;
                else if (irq_ack) state_nx = S_SVC;
            end
            S_SVC:  if (irq_eoi) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        irq      = (state == S_REQ);
        eoi_done = (state == S_SVC) && irq_eoi;
    end

    always_ff @(posedge clk) begin
        if (rst)                          irq_id <= '0;
        else if (state == S_IDLE && |req) irq_id <= req_id;
    end

endmodule

// File: tb/tb_irq_timer_bank.sv
// Bench for irq_timer_bank: register vectors, directed corner sequences and random
// traffic, all checked cycle by cycle against a behavioural model of the timer bank.
module tb_irq_timer_bank;

    localparam int N    = 4;
    localparam int MASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        wr_en = 1'b0, rd_en = 1'b0, irq_ack = 1'b0, irq_eoi = 1'b0;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  irq_id;

    always #5 clk = ~clk;

    irq_timer_bank #(.N_CH(N), .CNT_W(16), .PSC_W(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en),
        .rdata(rdata), .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack), .irq_eoi(irq_eoi)
    );

    int n_chk = 0, n_err = 0, cyc_n = 0;

    // Model: channel registers plus "which channel has an outstanding trap, acked or not".
    int unsigned m_cmp [N], m_cnt [N];
    bit          m_en [N], m_per [N], m_ie [N], m_pend [N];
    int unsigned m_psc, m_since;
    int          m_active, m_id;
    bit          m_acked;
    logic [31:0] m_rdata;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cmp[i] = 0; m_cnt[i] = 0; m_en[i] = 0; m_per[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
        end
        m_psc = 0; m_since = 0; m_active = -1; m_id = 0; m_acked = 0; m_rdata = '0;
    endfunction

    function automatic logic [31:0] reg_val(input int ch, input int r);
        case (r)
            0: return 32'(m_cmp[ch]);
            1: return {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
            2: return 32'(m_cnt[ch]);
            default: return 32'((ch == 0) ? (m_psc << 16) : 0) | 32'(m_pend[ch]);
        endcase
    endfunction

    task automatic model_step(input logic [3:0] a, input logic [31:0] wd,
                              input bit wr, input bit rd, input bit ack, input bit eoi);
        int ch, r, clr;
        bit tick, hit, ev, match;
        ch  = int'(a) / 4;
        r   = int'(a) % 4;
        clr = -1;
        if (rd) m_rdata = reg_val(ch, r);
        tick = (m_since >= m_psc);
        if (m_active < 0) begin
            for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_ie[i]) m_active = i;
            if (m_active >= 0) begin m_id = m_active; m_acked = 0; end
        end else if (!m_acked) begin
            if (!(m_pend[m_active] && m_ie[m_active])) m_active = -1;
            else if (ack) m_acked = 1;
        end else if (eoi) begin
            clr = m_active;
            m_active = -1;
        end
        for (int i = 0; i < N; i++) begin
            hit   = wr && (ch == i);
            ev    = tick && m_en[i] && !(hit && (r == 1 || r == 2));
            match = ev && (m_cnt[i] == m_cmp[i]);
            if (hit && r == 0) m_cmp[i] = wd & MASK;
            if (hit && r == 1) begin
                m_en[i] = wd[0]; m_per[i] = wd[1]; m_ie[i] = wd[2];
            end else if (match && !m_per[i]) m_en[i] = 0;
            if (hit && r == 2) m_cnt[i] = wd & MASK;
            else if (match) m_cnt[i] = m_per[i] ? 0 : m_cnt[i];
            else if (ev) m_cnt[i] = (m_cnt[i] + 1) & MASK;
            if (match) m_pend[i] = 1;
            else if ((hit && r == 3 && wd[0]) || clr == i) m_pend[i] = 0;
        end
        if (wr && ch == 0 && r == 3) m_psc = (wd >> 16) & 32'hFF;
        m_since = tick ? 0 : m_since + 1;
    endtask

    task automatic cyc(input logic [3:0] a, input logic [31:0] wd,
                       input bit wr, input bit rd, input bit ack, input bit eoi);
        addr = a; wdata = wd; wr_en = wr; rd_en = rd; irq_ack = ack; irq_eoi = eoi;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(a, wd, wr, rd, ack, eoi);
        #1;
        cyc_n++;
        chk("irq", 32'(irq), 32'(m_active >= 0 && !m_acked));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic idle();                                    cyc(4'd0, 0, 0, 0, 0, 0); endtask
    task automatic t_wr(input logic [3:0] a, input logic [31:0] d); cyc(a, d, 1, 0, 0, 0); endtask
    task automatic t_rd(input logic [3:0] a);                 cyc(a, 0, 0, 1, 0, 0); endtask
    task automatic t_ack();                                   cyc(4'd0, 0, 0, 0, 1, 0); endtask
    task automatic t_eoi();                                   cyc(4'd0, 0, 0, 0, 0, 1); endtask
    task automatic do_reset(); rst = 1'b1; idle(); rst = 1'b0; endtask

    task automatic wait_irq(input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            idle();
            if (irq === 1'b1) begin k = i; break; end
        end
    endtask

    initial begin
        int k, hits;
        vt[0] = '{4'd0,  32'h1234_5678, 32'h0000_5678};
        vt[1] = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0007};
        vt[2] = '{4'd1,  32'h0000_0000, 32'h0000_0000};
        vt[3] = '{4'd4,  32'h0000_ABCD, 32'h0000_ABCD};
        vt[4] = '{4'd14, 32'hFFFF_0001, 32'h0000_0001};
        vt[5] = '{4'd13, 32'h0000_0006, 32'h0000_0006};
        vt[6] = '{4'd3,  32'h00A5_0000, 32'h00A5_0000};
        vt[7] = '{4'd7,  32'hFFFF_0000, 32'h0000_0000};

        do_reset();
        chk("reset_irq", 32'(irq), 0);
        chk("reset_rdata", rdata, 0);
        for (int i = 0; i < 8; i++) begin
            t_wr(vt[i].a, vt[i].d);
            t_rd(vt[i].a);
            chk($sformatf("vec%0d", i), rdata, vt[i].exp);
        end

        // periodic channel 0, CMP=5
        do_reset();
        t_wr(4'd0, 5);
        t_wr(4'd1, 7);
        wait_irq(20, k);
        chk("t1_first_latency", 32'(k), 7);
        chk("t1_id", 32'(irq_id), 0);
        t_ack();
        t_eoi();
        t_rd(4'd3);
        chk("t1_pend_cleared", rdata, 0);
        wait_irq(20, k);
        chk("t1_second_latency", 32'(k), 3);

        // one-shot channel 1 with PSC=3
        do_reset();
        t_wr(4'd3, 32'h0003_0000);
        t_wr(4'd4, 2);
        t_wr(4'd5, 5);
        wait_irq(20, k);
        chk("t2_latency", 32'(k), 11);
        chk("t2_id", 32'(irq_id), 1);
        t_rd(4'd5);
        chk("t2_ctrl_en_off", rdata, 4);
        t_rd(4'd6);
        chk("t2_cnt_hold", rdata, 2);
        t_ack();
        t_eoi();
        hits = 0;
        for (int i = 0; i < 40; i++) begin idle(); if (irq) hits++; end
        chk("t2_single_irq", 32'(hits), 0);

        // channels 0 and 2 matching on the same tick
        do_reset();
        t_wr(4'd0, 5);
        t_wr(4'd8, 5);
        t_wr(4'd1, 5);
        t_wr(4'd9, 5);
        t_wr(4'd10, 2);
        wait_irq(10, k);
        chk("t3_latency", 32'(k), 5);
        chk("t3_first_id", 32'(irq_id), 0);
        t_ack();
        t_eoi();
        idle();
        chk("t3_second_irq", 32'(irq), 1);
        chk("t3_second_id", 32'(irq_id), 2);
        t_ack();
        t_eoi();

        // counter wrap and software CNT write on a tick
        do_reset();
        t_wr(4'd4, 3);
        t_wr(4'd6, 32'h0000_FFFF);
        t_wr(4'd5, 5);
        wait_irq(10, k);
        chk("t4_wrap_latency", 32'(k), 6);
        t_rd(4'd6);
        chk("t4_cnt_after_match", rdata, 3);
        t_ack();
        t_eoi();
        t_wr(4'd4, 100);
        t_wr(4'd5, 1);
        t_wr(4'd6, 50);
        t_rd(4'd6);
        chk("t4_sw_write_wins", rdata, 50);

        // W1C colliding with match, then request withdrawn by clearing IE
        do_reset();
        t_wr(4'd0, 3);
        t_wr(4'd1, 5);
        idle(); idle(); idle();
        t_wr(4'd3, 1);
        t_rd(4'd3);
        chk("t5_set_beats_w1c", rdata, 1);
        chk("t5_irq_raised", 32'(irq), 1);
        t_wr(4'd1, 0);
        chk("t5_irq_still_up", 32'(irq), 1);
        idle();
        chk("t5_irq_withdrawn", 32'(irq), 0);
        idle(); idle();
        t_wr(4'd1, 4);
        idle();
        chk("t5_reissue_no_ack", 32'(irq), 1);

        // reset during service
        do_reset();
        t_wr(4'd1, 7);
        wait_irq(5, k);
        chk("t6_latency", 32'(k), 2);
        t_ack();
        t_rd(4'd1);
        chk("t6_rdata_before_rst", rdata, 7);
        do_reset();
        chk("t6_rst_irq", 32'(irq), 0);
        chk("t6_rst_rdata", rdata, 0);
        t_eoi();
        chk("t6_eoi_ignored", 32'(irq), 0);
        for (int a = 0; a < 16; a++) begin
            t_rd(4'(a));
            chk($sformatf("t6_reg%0d_zero", a), rdata, 0);
        end

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  a;
            logic [31:0] d;
            a = 4'($urandom_range(0, 15));
            case (a[1:0])
                2'd0: d = $urandom_range(0, 12);
                2'd1: d = $urandom;
                2'd2: d = ($urandom_range(0, 19) == 0) ? 32'h0000_FFFF : $urandom_range(0, 12);
                default: d = ((a[3:2] == 2'd0) ? ($urandom_range(0, 2) << 16) : ($urandom & 32'hFFFF_FFFE))
                             | $urandom_range(0, 1);
            endcase
            cyc(a, d, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
